// File: rtl/multicycle_ctrl_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, datapath control codes,
// FSM states and the load/store func3 legality check.
package multicycle_ctrl_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_FUNC = 2'd2,
        ALU_LUI  = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        BJ_B    = 2'd0,
        BJ_J    = 2'd1,
        BJ_JR   = 2'd2,
        BJ_NONE = 2'd3
    } is_bj_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } load_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Doubleword and LWU accesses only exist on the 64-bit datapath.
    function automatic logic mem_func3_legal(input logic is_store, input logic [2:0] f3,
                                             input int xlen);
        logic wide;
        logic ok;
        wide = (xlen == 64);
        ok   = 1'b0;
        if (is_store) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                3'b011:                 ok = wide;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                3'b011, 3'b110:                         ok = wide;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// Instruction-register, datapath-control and data-memory signals of the control unit.
// master is the control unit itself; slave is the datapath/memory side.
interface multicycle_ctrl_unit_if #(
    parameter int XLEN = 32
);
    localparam int STRB_W = XLEN / 8;

    logic              instr_valid;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [XLEN-1:0]   data_addr;
    logic              mem_ready;

    logic [2:0]        imm_type;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              pc_to_reg_src;
    logic              rd_src;
    logic              mem_to_reg;
    logic [1:0]        is_bj;
    logic              reg_write;
    logic              mem_read;
    logic [STRB_W-1:0] mem_write;
    logic [1:0]        load_size;
    logic              load_unsigned;
    logic              stall;
    logic              instr_done;
    logic              misalign;
    logic              illegal;

    modport master (
        input  instr_valid, opcode, func3, data_addr, mem_ready,
        output imm_type, alu_op, alu_src, pc_to_reg_src, rd_src, mem_to_reg, is_bj,
               reg_write, mem_read, mem_write, load_size, load_unsigned,
               stall, instr_done, misalign, illegal
    );

    modport slave (
        output instr_valid, opcode, func3, data_addr, mem_ready,
        input  imm_type, alu_op, alu_src, pc_to_reg_src, rd_src, mem_to_reg, is_bj,
               reg_write, mem_read, mem_write, load_size, load_unsigned,
               stall, instr_done, misalign, illegal
    );

endinterface

// File: rtl/multicycle_ctrl_unit_store_strobe_gen.sv
// Byte-lane strobe and alignment check for a memory access of the given size
// at the low address bits of the effective address.
module store_strobe_gen
    import multicycle_ctrl_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int ADDR_W = $clog2(STRB_W)
) (
    input  load_size_e        size,
    input  logic [ADDR_W-1:0] addr,
    output logic [STRB_W-1:0] strobe,
    output logic              misaligned
);

    always_comb begin
        strobe     = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: strobe = STRB_W'(1) << addr;
            SIZE_H: begin
                strobe     = STRB_W'(3) << addr;
                misaligned = addr[0];
            end
            SIZE_W: begin
                strobe     = STRB_W'(4'hF) << addr;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: begin
                strobe     = '1;
                misaligned = (addr != '0);
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Main control for the multi-cycle core: single-cycle decode of non-memory ops and an
// IDLE/REQ/WAIT/WB sequencer for loads and stores that stalls the PC while memory is busy.
module multicycle_ctrl_unit
    import multicycle_ctrl_unit_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int LOAD_WAIT     = 1,
    parameter int MISALIGN_TRAP = 1
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_ctrl_unit_if.master bus
);

    localparam int STRB_W = XLEN / 8;
    localparam int ADDR_W = $clog2(STRB_W);
    localparam logic [2:0] WAIT_INIT = 3'((LOAD_WAIT > 0) ? LOAD_WAIT - 1 : 0);

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        func3_q, func3_d;
    logic [STRB_W-1:0] strobe_q, strobe_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;

    logic [STRB_W-1:0] strobe;
    logic              misaligned;
    logic              decode_bad;
    logic              unused_addr_hi;

    imm_type_e         imm_type;
    alu_op_e           alu_op;
    is_bj_e            is_bj;
    load_size_e        load_size;
    logic              alu_src;
    logic              pc_to_reg_src;
    logic              rd_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic [STRB_W-1:0] mem_write;
    logic              load_unsigned;
    logic              stall;
    logic              instr_done;
    logic              misalign;
    logic              illegal;

    assign unused_addr_hi = ^bus.data_addr[XLEN-1:ADDR_W];

    store_strobe_gen #(.XLEN(XLEN)) u_strobe (
        .size       (load_size_e'(bus.func3[1:0])),
        .addr       (bus.data_addr[ADDR_W-1:0]),
        .strobe     (strobe),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            func3_q    <= 3'd0;
            strobe_q   <= '0;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            func3_q    <= func3_d;
            strobe_q   <= strobe_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are held at the bubble pattern while rst is high so nothing retires in reset.
    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        func3_d       = func3_q;
        strobe_d      = strobe_q;
        wait_cnt_d    = wait_cnt_q;
        decode_bad    = 1'b0;
        imm_type      = IMM_R;
        alu_op        = ALU_ADD;
        is_bj         = BJ_NONE;
        load_size     = SIZE_B;
        alu_src       = 1'b0;
        pc_to_reg_src = 1'b0;
        rd_src        = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = '0;
        load_unsigned = 1'b0;
        stall         = 1'b0;
        instr_done    = 1'b0;
        misalign      = 1'b0;
        illegal       = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        case (bus.opcode)
                            OP_REG: begin
                                alu_op     = ALU_FUNC;
                                alu_src    = 1'b1;
                                mem_to_reg = 1'b1;
                                reg_write  = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_IMM: begin
                                imm_type   = IMM_I;
                                alu_op     = ALU_FUNC;
                                mem_to_reg = 1'b1;
                                reg_write  = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_JALR: begin
                                if (bus.func3 == 3'b000) begin
                                    imm_type   = IMM_I;
                                    rd_src     = 1'b1;
                                    mem_to_reg = 1'b1;
                                    is_bj      = BJ_JR;
                                    reg_write  = 1'b1;
                                    instr_done = 1'b1;
                                end else begin
                                    decode_bad = 1'b1;
                                end
                            end
                            OP_BRANCH: begin
                                if (bus.func3[2:1] != 2'b01) begin
                                    imm_type   = IMM_B;
                                    alu_op     = ALU_SUB;
                                    alu_src    = 1'b1;
                                    mem_to_reg = 1'b1;
                                    is_bj      = BJ_B;
                                    instr_done = 1'b1;
                                end else begin
                                    decode_bad = 1'b1;
                                end
                            end
                            OP_AUIPC: begin
                                imm_type      = IMM_U;
                                pc_to_reg_src = 1'b1;
                                rd_src        = 1'b1;
                                mem_to_reg    = 1'b1;
                                reg_write     = 1'b1;
                                instr_done    = 1'b1;
                            end
                            OP_LUI: begin
                                imm_type   = IMM_U;
                                alu_op     = ALU_LUI;
                                mem_to_reg = 1'b1;
                                reg_write  = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_JAL: begin
                                imm_type   = IMM_J;
                                rd_src     = 1'b1;
                                mem_to_reg = 1'b1;
                                is_bj      = BJ_J;
                                reg_write  = 1'b1;
                                instr_done = 1'b1;
                            end
                            OP_LOAD, OP_STORE: begin
                                if (!mem_func3_legal(bus.opcode == OP_STORE, bus.func3, XLEN)) begin
                                    decode_bad = 1'b1;
                                end else begin
                                    imm_type = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
                                    if (misaligned) begin
                                        instr_done = 1'b1;
                                        misalign   = (MISALIGN_TRAP != 0);
                                    end else begin
                                        stall      = 1'b1;
                                        is_store_d = (bus.opcode == OP_STORE);
                                        func3_d    = bus.func3;
                                        strobe_d   = (bus.opcode == OP_STORE) ? strobe : '0;
                                        state_d    = ST_REQ;
                                    end
                                end
                            end
                            default: decode_bad = 1'b1;
                        endcase
                        if (decode_bad) begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    stall = 1'b1;
                    if (is_store_q) begin
                        imm_type  = IMM_S;
                        mem_write = strobe_q;
                    end else begin
                        imm_type      = IMM_I;
                        mem_read      = 1'b1;
                        load_size     = load_size_e'(func3_q[1:0]);
                        load_unsigned = func3_q[2];
                    end
                    if (bus.mem_ready) begin
                        if (is_store_q) begin
                            stall      = 1'b0;
                            instr_done = 1'b1;
                            state_d    = ST_IDLE;
                        end else if (LOAD_WAIT > 0) begin
                            wait_cnt_d = WAIT_INIT;
                            state_d    = ST_WAIT;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WAIT: begin
                    stall         = 1'b1;
                    imm_type      = IMM_I;
                    load_size     = load_size_e'(func3_q[1:0]);
                    load_unsigned = func3_q[2];
                    if (wait_cnt_q == 3'd0) begin
                        state_d = ST_WB;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 3'd1;
                    end
                end
                ST_WB: begin
                    imm_type      = IMM_I;
                    load_size     = load_size_e'(func3_q[1:0]);
                    load_unsigned = func3_q[2];
                    reg_write     = 1'b1;
                    instr_done    = 1'b1;
                    state_d       = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.imm_type      = imm_type;
    assign bus.alu_op        = alu_op;
    assign bus.alu_src       = alu_src;
    assign bus.pc_to_reg_src = pc_to_reg_src;
    assign bus.rd_src        = rd_src;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.is_bj         = is_bj;
    assign bus.reg_write     = reg_write;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.load_size     = load_size;
    assign bus.load_unsigned = load_unsigned;
    assign bus.stall         = stall;
    assign bus.instr_done    = instr_done;
    assign bus.misalign      = misalign;
    assign bus.illegal       = illegal;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: a decode table on the 32-bit unit plus
// hand-written load/store/reset sequences on 32-bit, no-trap and 64-bit instances.
module tb_multicycle_ctrl_unit;
    import multicycle_ctrl_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_unit_if #(.XLEN(32)) if32 ();
    multicycle_ctrl_unit_if #(.XLEN(32)) if32nt ();
    multicycle_ctrl_unit_if #(.XLEN(64)) if64 ();

    multicycle_ctrl_unit #(.XLEN(32), .LOAD_WAIT(1), .MISALIGN_TRAP(1)) dut32 (
        .clk(clk), .rst(rst), .bus(if32)
    );
    multicycle_ctrl_unit #(.XLEN(32), .LOAD_WAIT(1), .MISALIGN_TRAP(0)) dut32nt (
        .clk(clk), .rst(rst), .bus(if32nt)
    );
    multicycle_ctrl_unit #(.XLEN(64), .LOAD_WAIT(2), .MISALIGN_TRAP(1)) dut64 (
        .clk(clk), .rst(rst), .bus(if64)
    );

    typedef struct packed {
        logic [2:0] imm_type;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       pc_to_reg_src;
        logic       rd_src;
        logic       mem_to_reg;
        logic [1:0] is_bj;
        logic       reg_write;
        logic       mem_read;
        logic       stall;
        logic       instr_done;
        logic       misalign;
        logic       illegal;
        logic [3:0] mem_write;
    } outs_t;

    typedef struct {
        string      name;
        logic       valid;
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [31:0] addr;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];

    function automatic outs_t mk(input int imm, input int alu, input int src, input int p2r,
                                 input int rd, input int m2r, input int bj, input int rw,
                                 input int mr, input int st, input int done, input int mis,
                                 input int ill, input int mw);
        outs_t o;
        o.imm_type      = 3'(imm);
        o.alu_op        = 2'(alu);
        o.alu_src       = 1'(src);
        o.pc_to_reg_src = 1'(p2r);
        o.rd_src        = 1'(rd);
        o.mem_to_reg    = 1'(m2r);
        o.is_bj         = 2'(bj);
        o.reg_write     = 1'(rw);
        o.mem_read      = 1'(mr);
        o.stall         = 1'(st);
        o.instr_done    = 1'(done);
        o.misalign      = 1'(mis);
        o.illegal       = 1'(ill);
        o.mem_write     = 4'(mw);
        return o;
    endfunction

    function automatic outs_t sample32();
        outs_t o;
        o = '{if32.imm_type, if32.alu_op, if32.alu_src, if32.pc_to_reg_src, if32.rd_src,
              if32.mem_to_reg, if32.is_bj, if32.reg_write, if32.mem_read, if32.stall,
              if32.instr_done, if32.misalign, if32.illegal, if32.mem_write};
        return o;
    endfunction

    function automatic outs_t sample32nt();
        outs_t o;
        o = '{if32nt.imm_type, if32nt.alu_op, if32nt.alu_src, if32nt.pc_to_reg_src,
              if32nt.rd_src, if32nt.mem_to_reg, if32nt.is_bj, if32nt.reg_write,
              if32nt.mem_read, if32nt.stall, if32nt.instr_done, if32nt.misalign,
              if32nt.illegal, if32nt.mem_write};
        return o;
    endfunction

    task automatic applyStimulus(input logic [2:0] mask, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [63:0] addr,
                                 input logic ready);
        @(negedge clk);
        if32.instr_valid   = mask[0];
        if32nt.instr_valid = mask[1];
        if64.instr_valid   = mask[2];
        if32.opcode   = op;  if32nt.opcode = op;  if64.opcode = op;
        if32.func3    = f3;  if32nt.func3  = f3;  if64.func3  = f3;
        if32.data_addr   = addr[31:0];
        if32nt.data_addr = addr[31:0];
        if64.data_addr   = addr;
        if32.mem_ready = ready; if32nt.mem_ready = ready; if64.mem_ready = ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        outs_t bubble, ill, r_add;
        bubble = mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        ill    = mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0);
        r_add  = mk(0, 2, 1, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0, 0);

        vecs.push_back('{"add",      1'b1, OP_REG,    3'b000, 32'h0,   r_add});
        vecs.push_back('{"addi",     1'b1, OP_IMM,    3'b000, 32'h0,   mk(1, 2, 0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"jalr",     1'b1, OP_JALR,   3'b000, 32'h0,   mk(1, 0, 0, 0, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"beq",      1'b1, OP_BRANCH, 3'b000, 32'h0,   mk(3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"bltu",     1'b1, OP_BRANCH, 3'b110, 32'h0,   mk(3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"auipc",    1'b1, OP_AUIPC,  3'b000, 32'h0,   mk(4, 0, 0, 1, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"lui",      1'b1, OP_LUI,    3'b000, 32'h0,   mk(4, 3, 0, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"jal",      1'b1, OP_JAL,    3'b000, 32'h0,   mk(5, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0)});
        vecs.push_back('{"op_zero",  1'b1, 7'h00,     3'b000, 32'h0,   ill});
        vecs.push_back('{"op_7f",    1'b1, 7'h7f,     3'b000, 32'h0,   ill});
        vecs.push_back('{"jalr_f1",  1'b1, OP_JALR,   3'b001, 32'h0,   ill});
        vecs.push_back('{"br_f2",    1'b1, OP_BRANCH, 3'b010, 32'h0,   ill});
        vecs.push_back('{"br_f3",    1'b1, OP_BRANCH, 3'b011, 32'h0,   ill});
        vecs.push_back('{"load_f7",  1'b1, OP_LOAD,   3'b111, 32'h0,   ill});
        vecs.push_back('{"store_f4", 1'b1, OP_STORE,  3'b100, 32'h0,   ill});
        vecs.push_back('{"ld_rv32",  1'b1, OP_LOAD,   3'b011, 32'h8,   ill});
        vecs.push_back('{"lwu_rv32", 1'b1, OP_LOAD,   3'b110, 32'h4,   ill});
        vecs.push_back('{"sd_rv32",  1'b1, OP_STORE,  3'b011, 32'h0,   ill});
        vecs.push_back('{"sw_mis",   1'b1, OP_STORE,  3'b010, 32'h101, mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{"lh_mis",   1'b1, OP_LOAD,   3'b001, 32'h103, mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{"lw_mis",   1'b1, OP_LOAD,   3'b010, 32'h102, mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0)});
        vecs.push_back('{"bubble",   1'b0, OP_REG,    3'b000, 32'h0,   bubble});

        rst = 1'b1;
        applyStimulus(3'b000, 7'h0, 3'b0, 64'h0, 1'b0);
        applyStimulus(3'b111, OP_REG, 3'b0, 64'h0, 1'b1);
        checkOutput("in_reset_32", sample32(), bubble);
        rst = 1'b0;
        applyStimulus(3'b000, 7'h0, 3'b0, 64'h0, 1'b0);
        checkOutput("reset_32", sample32(), bubble);
        checkOutput("reset_32nt", sample32nt(), bubble);
        checkValue("reset_64_is_bj", 64'(if64.is_bj), 64'd3);
        checkValue("reset_64_mem_write", 64'(if64.mem_write), 64'h0);
        checkValue("reset_64_flags", 64'({if64.stall, if64.instr_done, if64.reg_write, if64.mem_read}), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus({2'b00, vecs[i].valid}, vecs[i].opcode, vecs[i].func3,
                          64'(vecs[i].addr), 1'b0);
            checkOutput(vecs[i].name, sample32(), vecs[i].exp);
        end

        // LW with LOAD_WAIT=1: accept, REQ, WAIT, WB; inputs changed mid-flight must be ignored
        applyStimulus(3'b001, OP_LOAD, 3'b010, 64'h100, 1'b0);
        checkOutput("lw_accept", sample32(), mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(3'b001, OP_REG, 3'b000, 64'h3, 1'b1);
        checkOutput("lw_req", sample32(), mk(1, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0));
        checkValue("lw_req_size", 64'({if32.load_size, if32.load_unsigned}), 64'b100);
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkOutput("lw_wait", sample32(), mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkOutput("lw_wb", sample32(), mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0));
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkOutput("lw_after", sample32(), bubble);

        // SH to 0x102 with memory busy for three cycles
        applyStimulus(3'b001, OP_STORE, 3'b001, 64'h102, 1'b0);
        checkOutput("sh_accept", sample32(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
            checkOutput($sformatf("sh_busy%0d", i), sample32(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 4'b1100));
        end
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkOutput("sh_ready", sample32(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 4'b1100));
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkOutput("sh_after", sample32(), bubble);

        // SB to address 0 uses lane 0; mem_ready during accept is ignored
        applyStimulus(3'b001, OP_STORE, 3'b000, 64'h0, 1'b1);
        checkOutput("sb0_accept", sample32(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkOutput("sb0_req", sample32(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 4'b0001));

        // Misaligned SW with and without trapping
        applyStimulus(3'b011, OP_STORE, 3'b010, 64'h101, 1'b0);
        checkOutput("sw_mis_trap", sample32(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0));
        checkOutput("sw_mis_notrap", sample32nt(), mk(2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0));
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkOutput("sw_mis_idle", sample32(), bubble);
        checkOutput("sw_mis_idle_nt", sample32nt(), bubble);

        // 64-bit unit: SB lane 7, LD with two wait cycles, misaligned SD
        applyStimulus(3'b100, OP_STORE, 3'b000, 64'h7, 1'b0);
        checkValue("sb64_accept", 64'({if64.stall, if64.mem_write}), 64'h100);
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkValue("sb64_req", 64'({if64.stall, if64.instr_done, if64.mem_write}), 64'h180);
        applyStimulus(3'b100, OP_LOAD, 3'b011, 64'h8, 1'b0);
        checkValue("ld64_accept", 64'({if64.stall, if64.illegal, if64.instr_done}), 64'b100);
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkValue("ld64_req", 64'({if64.mem_read, if64.load_size, if64.load_unsigned}), 64'b1110);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
            checkValue($sformatf("ld64_wait%0d", i),
                       64'({if64.stall, if64.mem_read, if64.instr_done, if64.reg_write}), 64'b1000);
        end
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkValue("ld64_wb", 64'({if64.stall, if64.instr_done, if64.reg_write, if64.mem_to_reg}), 64'b0110);
        applyStimulus(3'b100, OP_STORE, 3'b011, 64'h4, 1'b0);
        checkValue("sd64_mis", 64'({if64.stall, if64.instr_done, if64.misalign, if64.mem_write}), 64'h300);

        // Reset while a load sits in WAIT: nothing retires afterwards
        applyStimulus(3'b001, OP_LOAD, 3'b100, 64'h201, 1'b0);
        checkOutput("lbu_accept", sample32(), mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b1);
        checkValue("lbu_req", 64'({if32.mem_read, if32.load_size, if32.load_unsigned}), 64'b1001);
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkOutput("lbu_wait", sample32(), mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkOutput("rst_wait_next", sample32(), bubble);
        applyStimulus(3'b000, OP_REG, 3'b000, 64'h0, 1'b0);
        checkOutput("rst_wait_next2", sample32(), bubble);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
